seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial pattern detector for single-bit streams. It detects a runtime-loadable PAT_LEN-bit pattern, in overlapping or non-overlapping mode, and accepts input only on qualified cycles. It produces a registered one-cycle detect pulse and a saturating match counter. It sits on a serial input path and replaces fixed-pattern, hard-coded FSM detectors; the pattern is a register value, not a state encoding.

## Interface
- PAT_LEN, 4: pattern length in bits; legal range 2..32.
- RESET_PAT, 4'b1011: pattern register value after reset. Width PAT_LEN. Bit PAT_LEN-1 is the first bit received.
- CNT_W, 8: match counter width; minimum 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- seq_in  in  1  serial data bit.
- in_valid  in  1  seq_in is sampled only when this is high.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- pattern_in  in  PAT_LEN  new pattern, same bit order as RESET_PAT.
- pattern_load  in  1  load pattern_in into the pattern register.
- count_clr  in  1  synchronous clear of match_count.
- detect_out  out  1  registered one-cycle pulse per match.
- match_count  out  CNT_W  saturating count of matches.
- count_sat  out  1  high while match_count is all ones.

## Operation
- State:
  - pat_reg[PAT_LEN-1:0]
  - hist[PAT_LEN-1:0], a shift register with the newest bit at bit 0
  - fill, a counter of width clog2(PAT_LEN+1) that saturates at PAT_LEN
  - match_count
  - detect_out register
- Reset (async, takes effect immediately): pat_reg=RESET_PAT, hist=0, fill=0, detect_out=0, match_count=0, count_sat=0.
- Per rising edge, in priority order:
  1. pattern_load=1:
     - pat_reg<=pattern_in; hist<=0; fill<=0; detect_out<=0.
     - The seq_in sample is discarded even if in_valid=1.
  2. Else if in_valid=1:
     - hist_n={hist[PAT_LEN-2:0],seq_in}; fill_n=min(fill+1,PAT_LEN).
     - hit = (hist_n==pat_reg) && (fill_n==PAT_LEN).
     - detect_out<=hit; hist<=hist_n.
     - fill<=0 if (hit && !overlap_en), else fill_n.
  3. Else: detect_out<=0; hist and fill hold.
- The fill gate guarantees no match on stale or zero history. For example, pattern 0000 does not match until 4 valid bits have been received.
- Non-overlapping mode: after a hit, the next match needs PAT_LEN fresh valid bits.
- Overlapping mode: a match is possible on every valid bit after the first hit.
- overlap_en is sampled on the same edge as the hit it governs. Changing it mid-stream affects only later hits.
- Counter, applied after the detect logic on the same edge:
  - count_clr=1: match_count<=0. Clear wins over a simultaneous hit.
  - Else if hit and match_count is not all ones: increment.
  - At all ones: hold.
  - count_sat is registered and equals (match_count==all ones).
- A hit suppressed by pattern_load does not count.

## Timing
- Latency: the edge that samples the final pattern bit sets detect_out=1 for exactly one cycle. match_count updates on that same edge.
- detect_out is never high for two consecutive cycles unless overlap_en=1 and consecutive valid bits both complete the pattern. Example: pattern 1111 with a continuous run of 1s.
- in_valid gaps of any length insert no state change. The pattern may straddle gaps.
- A pattern load completes in one cycle. The first possible hit with the new pattern is PAT_LEN valid cycles after the load edge.
- Reset asserted mid-stream clears partial progress immediately. The first post-reset hit needs PAT_LEN valid bits.

## Test plan
- Defaults, overlap_en=1, valid stream 1,0,1,1,0,1,1 -> detect_out pulses after the 4th and 7th bits; match_count=2.
- Same stream, overlap_en=0 -> single pulse after the 4th bit; match_count=1.
- pattern_load 4'b0000 after reset, then valid zeros -> no pulse on bits 1-3; pulse on bit 4, then on every bit in overlap mode, or every 4th bit in non-overlap mode.
- Stream 1,0,1,1 with in_valid low for 3 cycles between every bit -> exactly one pulse, on the edge sampling the last 1.
- CNT_W=2, overlap_en=1, 5 matches -> match_count 1,2,3,3,3 and count_sat high from the 3rd match. count_clr coincident with a hit -> match_count=0, detect_out still 1.
- Sequence 1,0,1, reset pulse, then 1 -> no detect. Then 0,1,1 -> still no detect until a full 1,0,1,1 arrives after reset. pattern_load coincident with a completing bit -> no pulse, no count.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial detector for a runtime-loadable PAT_LEN-bit pattern.
// The pattern is held in a register, so there is no pattern-specific state
// encoding. A fill counter keeps the detector from matching on stale or
// zero-initialised history. It produces a one-cycle detect pulse and a
// saturating match counter.
module seq_detector_param #(
  parameter int                 PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0] RESET_PAT = 4'b1011,
  parameter int                 CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seq_in,
  input  logic               in_valid,
  input  logic               overlap_en,
  input  logic [PAT_LEN-1:0] pattern_in,
  input  logic               pattern_load,
  input  logic               count_clr,
  output logic               detect_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_LEN-1:0] pat_reg;
  logic [PAT_LEN-1:0] hist_reg;
  logic [PAT_LEN-1:0] hist_next;
  logic [FILL_W-1:0]  fill_reg;
  logic [FILL_W-1:0]  fill_next;
  logic               detect_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic               sat_reg;
  logic               hit;

  // Candidate history/fill for this bit, match decision and next count value.
  // A match needs PAT_LEN valid bits since the last load, reset or
  // non-overlapping hit.
  always_comb begin
    hist_next  = {hist_reg[PAT_LEN-2:0], seq_in};
    fill_next  = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + 1'b1;
    hit        = in_valid && !pattern_load &&
                 (hist_next == pat_reg) && (fill_next == FILL_FULL);
    count_next = count_reg;
    if (count_clr) begin
      count_next = '0;
    end else if (hit && (count_reg != CNT_MAX)) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Pattern register, history shift register, fill counter and detect pulse.
  // A pattern load discards any sample taken on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_reg    <= RESET_PAT;
      hist_reg   <= '0;
      fill_reg   <= '0;
      detect_reg <= 1'b0;
    end else if (pattern_load) begin
      pat_reg    <= pattern_in;
      hist_reg   <= '0;
      fill_reg   <= '0;
      detect_reg <= 1'b0;
    end else if (in_valid) begin
      detect_reg <= hit;
      hist_reg   <= hist_next;
      // Non-overlapping mode demands a completely fresh pattern after a hit.
      fill_reg   <= (hit && !overlap_en) ? '0 : fill_next;
    end else begin
      detect_reg <= 1'b0;
    end
  end

  // Saturating match counter; the saturation flag tracks the registered count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      sat_reg   <= (count_next == CNT_MAX);
    end
  end

  assign detect_out  = detect_reg;
  assign match_count = count_reg;
  assign count_sat   = sat_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param. It drives a wide-counter instance and a
// 2-bit-counter instance in parallel from one stimulus stream. Each
// transaction pushes its expected outputs to a queue, and the queue is
// popped and compared one tick after the sampling edge.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       seq_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap_en = 1'b1;
  logic [3:0] pattern_in = 4'b0000;
  logic       pattern_load = 1'b0;
  logic       count_clr = 1'b0;

  logic       det_a, sat_a;
  logic [7:0] cnt_a;
  logic       det_b, sat_b;
  logic [1:0] cnt_b;

  seq_detector_param #(.PAT_LEN(4), .RESET_PAT(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .overlap_en(overlap_en), .pattern_in(pattern_in),
    .pattern_load(pattern_load), .count_clr(count_clr),
    .detect_out(det_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  seq_detector_param #(.PAT_LEN(4), .RESET_PAT(4'b1011), .CNT_W(2)) dut_narrow (
    .clk(clk), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .overlap_en(overlap_en), .pattern_in(pattern_in),
    .pattern_load(pattern_load), .count_clr(count_clr),
    .detect_out(det_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       seq;
    bit       vld;
    bit       ovl;
    bit       ld;
    bit [3:0] pat;
    bit       clr;
    bit       det;
    int       cnt;
  } vec_t;

  typedef struct {
    bit det;
    int cnt;
    int cnt2;
    bit sat2;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;
  int   cnt2_m   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (txn %0d)", name, act, exp, n_txn);
    end
  endtask

  task automatic add(input bit seq, input bit vld, input bit ovl, input bit ld,
                     input bit [3:0] pat, input bit clr, input bit det, input int cnt);
    vec_t v;
    v.seq = seq; v.vld = vld; v.ovl = ovl; v.ld = ld;
    v.pat = pat; v.clr = clr; v.det = det; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    seq_in = v.seq; in_valid = v.vld; overlap_en = v.ovl;
    pattern_load = v.ld; pattern_in = v.pat; count_clr = v.clr;
    if (v.clr) cnt2_m = 0;
    else if (v.det && cnt2_m != 3) cnt2_m++;
    e.det = v.det; e.cnt = v.cnt; e.cnt2 = cnt2_m; e.sat2 = (cnt2_m == 3);
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_txn++;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("detect_out", int'(det_a), int'(e.det));
      check("match_count", int'(cnt_a), e.cnt);
      check("count_sat", int'(sat_a), 0);
      check("narrow_detect", int'(det_b), int'(e.det));
      check("narrow_count", int'(cnt_b), e.cnt2);
      check("narrow_sat", int'(sat_b), int'(e.sat2));
      $display("txn %0d: seq=%0d vld=%0d ovl=%0d ld=%0d clr=%0d -> det=%0d cnt=%0d cnt2=%0d sat2=%0d",
               n_txn, v.seq, v.vld, v.ovl, v.ld, v.clr, det_a, cnt_a, cnt_b, sat_b);
    end
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic step(input bit seq, input bit vld, input bit ld,
                      input bit [3:0] pat, input bit det, input int cnt);
    vec_t v;
    v.seq = seq; v.vld = vld; v.ovl = 1'b1; v.ld = ld;
    v.pat = pat; v.clr = 1'b0; v.det = det; v.cnt = cnt;
    apply(v);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    n_txn++;
    check("reset_detect", int'(det_a), 0);
    check("reset_count", int'(cnt_a), 0);
    check("reset_narrow_count", int'(cnt_b), 0);
    check("reset_narrow_sat", int'(sat_b), 0);
    $display("txn %0d: async reset -> det=%0d cnt=%0d cnt2=%0d", n_txn, det_a, cnt_a, cnt_b);
    cnt2_m = 0;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("por_detect", int'(det_a), 0);
    check("por_count", int'(cnt_a), 0);
    check("por_sat", int'(sat_b), 0);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Default pattern 1011, overlapping: hits on the 4th and 7th bits.
    add(1,1,1,0,0,0, 0,0); add(0,1,1,0,0,0, 0,0); add(1,1,1,0,0,0, 0,0);
    add(1,1,1,0,0,0, 1,1); add(0,1,1,0,0,0, 0,1); add(1,1,1,0,0,0, 0,1);
    add(1,1,1,0,0,0, 1,2);
    run_table();
    do_reset();

    // Same stream, non-overlapping: only the 4th bit hits.
    add(1,1,0,0,0,0, 0,0); add(0,1,0,0,0,0, 0,0); add(1,1,0,0,0,0, 0,0);
    add(1,1,0,0,0,0, 1,1); add(0,1,0,0,0,0, 0,1); add(1,1,0,0,0,0, 0,1);
    add(1,1,0,0,0,0, 0,1);
    add(0,0,0,0,0,1, 0,0);
    // Load 0000, then zeros in overlap mode: first hit on the 4th zero.
    add(0,0,1,1,4'b0000,0, 0,0);
    add(0,1,1,0,0,0, 0,0); add(0,1,1,0,0,0, 0,0); add(0,1,1,0,0,0, 0,0);
    add(0,1,1,0,0,0, 1,1); add(0,1,1,0,0,0, 1,2); add(0,1,1,0,0,0, 1,3);
    add(0,1,1,0,0,0, 1,4); add(0,1,1,0,0,0, 1,5);
    // Clear coincident with a hit: count clears, pulse still fires.
    add(0,1,1,0,0,1, 1,0);
    // Non-overlapping zeros: a hit every 4th bit.
    for (int i = 0; i < 9; i++) add(0,1,0,0,0,0, (i % 4) == 0, (i / 4) + 1);
    add(0,0,0,0,0,1, 0,0);
    // Reload 1011; bits separated by 3 invalid cycles carrying junk data.
    add(0,0,1,1,4'b1011,0, 0,0);
    for (int b = 0; b < 4; b++) begin
      bit bitv;
      bitv = (b != 1);
      add(bitv,1,1,0,0,0, b == 3, (b == 3) ? 1 : 0);
      for (int g = 0; g < 3; g++) add(!bitv,0,1,0,0,0, 0, (b == 3) ? 1 : 0);
    end
    run_table();

    // Partial pattern, reset, then the pattern must be received again in full.
    step(1,1,0,0, 0,1); step(0,1,0,0, 0,1); step(1,1,0,0, 0,1);
    do_reset();
    step(1,1,0,0, 0,0); step(0,1,0,0, 0,0); step(1,1,0,0, 0,0);
    step(1,1,0,0, 1,1);
    // Load coincident with the completing bit: no pulse, no count, history cleared.
    step(1,1,0,0, 0,1); step(0,1,0,0, 0,1); step(1,1,0,0, 0,1);
    step(1,1,1,4'b1011, 0,1);
    step(1,1,0,0, 0,1);

    if (sb.size() != 0) check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
